// File: rtl/qk_sequencer.sv
// Attention-core instruction sequencer: QWR, KWR, KLOAD, GAP, EXEC, DRAIN, NORM, DONE per start pulse.
// Outputs are registered decodes of the current state (one-cycle lag); no backpressure except ofifo_valid in DRAIN.
// Optional QKSEQ_SKIP_LOAD_EN adds skip_load, which jumps from IDLE straight to KLOAD.
module qk_sequencer #(
  parameter int col           = 8,
  parameter int max_len       = 16,
  parameter int load_gap      = 2,
  parameter int drain_timeout = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  q_len,
  input  logic        ofifo_valid,
`ifdef QKSEQ_SKIP_LOAD_EN
  input  logic        skip_load,
`endif
  output logic [16:0] inst,
  output logic        row_req,
  output logic [3:0]  row_idx,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int IW = $clog2(drain_timeout);
  localparam logic [3:0]    COL_LAST  = 4'(col - 1);
  localparam logic [3:0]    GAP_LAST  = 4'(load_gap - 1);
  localparam logic [3:0]    SUB_LAST  = 4'(col);
  localparam logic [IW-1:0] IDLE_LAST = IW'(drain_timeout - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_QWR, S_KWR, S_KLOAD, S_GAP, S_EXEC, S_DRAIN, S_NORM, S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic [3:0]    r_sub, w_sub_nxt;
  logic [3:0]    r_last, w_last_nxt;
  logic [IW-1:0] r_idle, w_idle_nxt;
  logic [16:0]   w_inst;
  logic          w_row_req, w_busy, w_done, w_err, w_len_ok, w_skip;
  logic [3:0]    w_row_idx;

`ifdef QKSEQ_SKIP_LOAD_EN
  assign w_skip = skip_load;
`else
  assign w_skip = 1'b0;
`endif
  assign w_len_ok = (q_len != 5'd0) && (q_len <= 5'(max_len));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sub_nxt   = r_sub;
    w_last_nxt  = r_last;
    w_idle_nxt  = r_idle;
    w_inst      = '0;
    w_row_req   = 1'b0;
    w_row_idx   = '0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy     = 1'b0;
        w_cnt_nxt  = '0;
        w_sub_nxt  = '0;
        w_idle_nxt = '0;
        if (start) begin
          if (w_len_ok) begin
            w_last_nxt  = 4'(q_len - 5'd1);
            w_state_nxt = w_skip ? S_KLOAD : S_QWR;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_QWR, S_KWR: begin
        w_inst[15:12] = r_cnt;
        w_inst[4]     = (r_state == S_QWR);
        w_inst[2]     = (r_state == S_KWR);
        w_row_req     = 1'b1;
        w_row_idx     = r_cnt;
        if (r_cnt == ((r_state == S_QWR) ? r_last : COL_LAST)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_state == S_QWR) ? S_KWR : S_KLOAD;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_KLOAD: begin
        w_inst[15:12] = r_cnt;
        w_inst[6]     = 1'b1;
        w_inst[3]     = 1'b1;
        if (r_cnt == COL_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_EXEC;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_EXEC: begin
        w_inst[15:12] = r_cnt;
        w_inst[7]     = 1'b1;
        w_inst[5]     = 1'b1;
        if (r_cnt == r_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DRAIN;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_DRAIN: begin
        // r_cnt is the psum write pointer; r_idle counts consecutive empty cycles
        if (ofifo_valid) begin
          w_inst[16]   = 1'b1;
          w_inst[11:8] = r_cnt;
          w_inst[0]    = 1'b1;
          w_idle_nxt   = '0;
          if (r_cnt == r_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_NORM;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end else if (r_idle == IDLE_LAST) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_idle_nxt = r_idle + 1'b1;
        end
      end
      S_NORM: begin
        // sub 0 reads the row, subs 1..col let the normaliser serialise it
        if (r_sub == 4'd0) begin
          w_inst[11:8] = r_cnt;
          w_inst[1]    = 1'b1;
        end
        if (r_sub == SUB_LAST) begin
          w_sub_nxt = '0;
          if (r_cnt == r_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end else begin
          w_sub_nxt = r_sub + 4'd1;
        end
      end
      S_DONE: begin
        w_busy      = 1'b0;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sub   <= '0;
      r_last  <= '0;
      r_idle  <= '0;
      inst    <= '0;
      row_req <= 1'b0;
      row_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sub   <= w_sub_nxt;
      r_last  <= w_last_nxt;
      r_idle  <= w_idle_nxt;
      inst    <= w_inst;
      row_req <= w_row_req;
      row_idx <= w_row_idx;
      busy    <= w_busy;
      done    <= w_done;
      err     <= w_err;
    end
  end

endmodule

// File: tb/tb_qk_sequencer.sv
// Scoreboard bench for qk_sequencer: a phase-level model builds each pass's expected output trace.
module tb_qk_sequencer;
  localparam int COL = 8, MAXL = 16, GAPN = 2, TMO = 64;

  logic        clk = 1'b0;
  logic        reset, start, ofifo_valid;
  logic [4:0]  q_len;
`ifdef QKSEQ_SKIP_LOAD_EN
  logic        skip_load;
`endif
  logic [16:0] inst;
  logic        row_req, busy, done, err;
  logic [3:0]  row_idx;

  typedef struct packed {
    logic [16:0] inst;
    logic        row_req;
    logic [3:0]  row_idx;
    logic        busy;
    logic        done;
    logic        err;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  obs_t  tr_exp[$];
  logic  tr_vld[$];
  int    checks = 0, errors = 0;

  qk_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .q_len(q_len), .ofifo_valid(ofifo_valid),
`ifdef QKSEQ_SKIP_LOAD_EN
    .skip_load(skip_load),
`endif
    .inst(inst), .row_req(row_req), .row_idx(row_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    obs_t  e, a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a.inst = inst; a.row_req = row_req; a.row_idx = row_idx;
      a.busy = busy; a.done = done; a.err = err;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got inst=%h rreq=%b ridx=%0d busy=%b done=%b err=%b, want inst=%h rreq=%b ridx=%0d busy=%b done=%b err=%b",
                 t, a.inst, a.row_req, a.row_idx, a.busy, a.done, a.err,
                 e.inst, e.row_req, e.row_idx, e.busy, e.done, e.err);
      end
    end
  end

  function automatic obs_t mk(input int iw, input logic rr, input int ri,
                              input logic b, input logic d, input logic e);
    obs_t o;
    o.inst = 17'(iw); o.row_req = rr; o.row_idx = 4'(ri);
    o.busy = b; o.done = d; o.err = e;
    return o;
  endfunction

  function automatic logic pat(input int mode, input int d);
    case (mode)
      0:       return 1'b1;
      1:       return (d % 4 == 0) || (d % 4 == 3);
      2:       return 1'($urandom_range(0, 1));
      default: return 1'b0;
    endcase
  endfunction

  task automatic put(input obs_t o, input logic v);
    tr_exp.push_back(o);
    tr_vld.push_back(v);
  endtask

  // Expected trace of one pass: entry k is what the outputs show just after clock edge k,
  // where edge 0 samples start; tr_vld[k] is the ofifo_valid driven into edge k.
  task automatic build_pass(input int len, input bit skip, input int mode);
    int writes, idle, d;
    tr_exp.delete();
    tr_vld.delete();
    if (len < 1 || len > MAXL) begin
      put(mk(0, 0, 0, 0, 0, 1), 1'($urandom_range(0, 1)));
      return;
    end
    put(mk(0, 0, 0, 0, 0, 0), 1'($urandom_range(0, 1)));
    if (!skip) begin
      for (int r = 0; r < len; r++) put(mk((r << 12) | (1 << 4), 1, r, 1, 0, 0), 1'($urandom_range(0, 1)));
      for (int r = 0; r < COL; r++) put(mk((r << 12) | (1 << 2), 1, r, 1, 0, 0), 1'($urandom_range(0, 1)));
    end
    for (int r = 0; r < COL; r++) put(mk((r << 12) | (1 << 6) | (1 << 3), 0, 0, 1, 0, 0), 1'($urandom_range(0, 1)));
    for (int g = 0; g < GAPN; g++) put(mk(0, 0, 0, 1, 0, 0), 1'($urandom_range(0, 1)));
    for (int r = 0; r < len; r++) put(mk((r << 12) | (1 << 7) | (1 << 5), 0, 0, 1, 0, 0), 1'($urandom_range(0, 1)));
    writes = 0; idle = 0; d = 0;
    while (writes < len) begin
      if (pat(mode, d)) begin
        put(mk((1 << 16) | (writes << 8) | 1, 0, 0, 1, 0, 0), 1'b1);
        writes++;
        idle = 0;
      end else begin
        idle++;
        if (idle == TMO) begin
          put(mk(0, 0, 0, 1, 0, 1), 1'b0);
          return;
        end
        put(mk(0, 0, 0, 1, 0, 0), 1'b0);
      end
      d++;
    end
    for (int r = 0; r < len; r++) begin
      put(mk((r << 8) | (1 << 1), 0, 0, 1, 0, 0), 1'($urandom_range(0, 1)));
      for (int c = 0; c < COL; c++) put(mk(0, 0, 0, 1, 0, 0), 1'($urandom_range(0, 1)));
    end
    put(mk(0, 0, 0, 0, 1, 0), 1'($urandom_range(0, 1)));
  endtask

  task automatic expect_now(input obs_t o, input string t);
    exp_q.push_back(o);
    tag_q.push_back(t);
  endtask

  task automatic run_pass(input logic [4:0] len, input bit skip, input int mode, input int abort_at);
    build_pass(int'(len), skip, mode);
    for (int k = 0; k < tr_exp.size(); k++) begin
      if (k == abort_at) begin
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        expect_now(mk(0, 0, 0, 0, 0, 0), $sformatf("abort_len%0d", len));
        return;
      end
      // start pulses after the first are issued while busy and must be ignored
      start = (k == 0) ? 1'b1 : ($urandom_range(0, 7) == 0);
      q_len = (k == 0) ? len : 5'($urandom_range(0, 31));
`ifdef QKSEQ_SKIP_LOAD_EN
      skip_load = (k == 0) ? skip : 1'($urandom_range(0, 1));
`endif
      ofifo_valid = tr_vld[k];
      @(posedge clk);
      #1;
      expect_now(tr_exp[k], $sformatf("len%0d_m%0d_k%0d", len, mode, k));
    end
    start = 1'b0;
    repeat (2) begin
      ofifo_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      expect_now(mk(0, 0, 0, 0, 0, 0), $sformatf("post_len%0d", len));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; q_len = '0; ofifo_valid = 1'b0;
`ifdef QKSEQ_SKIP_LOAD_EN
    skip_load = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    expect_now(mk(0, 0, 0, 0, 0, 0), "reset_state");
    reset = 1'b0;

    run_pass(5'd16, 1'b0, 0, -1);
    run_pass(5'd0, 1'b0, 0, -1);
    run_pass(5'd17, 1'b0, 0, -1);
    run_pass(5'd4, 1'b0, 1, -1);
    run_pass(5'd3, 1'b0, 3, -1);
    run_pass(5'd5, 1'b0, 0, 26);
    run_pass(5'd5, 1'b0, 2, -1);
    run_pass(5'd1, 1'b0, 2, -1);
    for (int i = 0; i < 5; i++) run_pass(5'($urandom_range(1, 16)), 1'b0, 2, -1);
`ifdef QKSEQ_SKIP_LOAD_EN
    run_pass(5'd6, 1'b1, 0, -1);
    run_pass(5'd16, 1'b1, 2, -1);
`endif

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_scoreboard: %0d entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
